// File: rtl/mux_2g157_arbiter.sv
// Two-requester arbiter driving a 2G157-style 2:1 mux with break-before-make sequencing.
// All outputs are flops; sel only moves while the mux output is gated off (ng=1).
module mux_2g157_arbiter #(
    parameter int MAX_HOLD   = 15,
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic ng
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // gap counter loads GAP_CYCLES-1 and counts down to zero
    localparam int GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, GRANT, GAP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              sel_q, sel_d;
    logic              ng_q, ng_d;
    logic              gnt_a_q, gnt_a_d;
    logic              gnt_b_q, gnt_b_d;

    logic req_own, req_oth, any_req, win, preempt;

    assign req_own = owner_q ? req_b : req_a;
    assign req_oth = owner_q ? req_a : req_b;
    assign any_req = req_a | req_b;
    // on a tie the requester that was not granted last wins
    assign win     = (req_a & req_b) ? ~last_q : req_b;
    assign preempt = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && req_oth;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= '0;
            gap_q   <= '0;
            sel_q   <= 1'b0;
            ng_q    <= 1'b1;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            ng_q    <= ng_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        ng_d    = ng_q;
        gnt_a_d = gnt_a_q;
        gnt_b_d = gnt_b_q;
        case (state_q)
            IDLE: begin
                ng_d    = 1'b1;
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
                if (any_req) begin
                    owner_d = win;
                    sel_d   = win;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (req_own) begin
                    state_d = GRANT;
                    ng_d    = 1'b0;
                    gnt_a_d = ~owner_q;
                    gnt_b_d = owner_q;
                    last_d  = owner_q;
                    hold_d  = HOLD_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req_own || preempt) begin
                    state_d = GAP;
                    ng_d    = 1'b1;
                    gnt_a_d = 1'b0;
                    gnt_b_d = 1'b0;
                    gap_d   = GAP_LOAD;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (any_req) begin
                    owner_d = win;
                    sel_d   = win;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign sel   = sel_q;
    assign ng    = ng_q;

endmodule

// File: doc/mux_2g157_arbiter.md
# mux_2g157_arbiter

Two-requester arbiter and sequencer for a shared 74x2G157-style 2:1 multiplexer path. It decides which requester owns the mux and drives the mux `sel` and `ng` (active-low gate) pins. Every changeover is break-before-make: the mux output is gated off before `sel` moves and is only re-enabled after `sel` has been stable for a cycle. It sits between two bus masters (A on mux input `a`, B on mux input `b`) and the mux.

## Interface
- `MAX_HOLD`, 15: maximum grant cycles before a waiting requester preempts the owner; 0 disables preemption.
- `GAP_CYCLES`, 1: number of gated-off cycles after a grant ends; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `nreset`  in  1  reset; one clock, asynchronous, active-low.
- `req_a`  in  1  requester A wants the path (mux input `a`, sel=0).
- `req_b`  in  1  requester B wants the path (mux input `b`, sel=1).
- `gnt_a`  out  1  A owns the path, registered.
- `gnt_b`  out  1  B owns the path, registered.
- `sel`  out  1  to mux `sel`, registered.
- `ng`  out  1  to mux `ng`, registered; 1 forces y=0 and ny=1.

## Operation
- States: IDLE, SETUP, GRANT, GAP. Also registered: `owner` (0=A, 1=B), `last` (last granted requester), hold counter (width clog2(MAX_HOLD+1), minimum 1), and gap counter.
- Reset values: state IDLE, `sel`=0, `ng`=1, `gnt_a`=0, `gnt_b`=0, `last`=B (so A wins the first tie), both counters 0. Asserting `nreset` mid-operation forces these values immediately, without waiting for a clock edge.
- IDLE: `ng`=1, no grant.
  - If exactly one req is high, it wins.
  - If both are high, the one that is not `last` wins.
  - On a win: `owner` and `sel` are set to the winner, and the next state is SETUP.
  - If no req is high, stay in IDLE with `sel` unchanged.
- SETUP: lasts one cycle. `ng`=1 while `sel` settles.
  - Next edge, if req[owner] is still high: enter GRANT. Set `ng`=0, gnt[owner]=1, `last`=`owner`, hold counter=1.
  - If req[owner] has dropped: return to IDLE with no grant. `last` is unchanged.
- GRANT: `ng`=0, gnt[owner]=1, and `sel` is frozen.
  - If req[owner] drops: enter GAP on the next edge.
  - Preemption: if MAX_HOLD≠0, hold counter == MAX_HOLD, and the other req is high, enter GAP even though req[owner] is still high.
  - Otherwise the hold counter increments each cycle and saturates at MAX_HOLD.
- GAP: entry edge sets gnt=0 and `ng`=1; `sel` is held. The state lasts GAP_CYCLES cycles.
  - The final GAP edge arbitrates exactly like IDLE: winner → SETUP, nothing pending → IDLE.
  - Round-robin through `last` guarantees the preempted requester is served after the other one.
- Invariants:
  - Never `gnt_a`&`gnt_b`.
  - gnt_x=1 ⇒ `ng`=0 and `sel`=x.
  - `sel` changes only on an edge where `ng` is 1 both before and after that edge.
  - `ng`=0 only in GRANT.

## Timing
- All outputs come straight from flops, with no combinational path from req to outputs.
- Grant latency from IDLE: req high at edge N → SETUP after N (`sel` valid, `ng`=1) → grant and `ng`=0 after edge N+1.
- Release: req drops before edge M → gnt=0 and `ng`=1 after M.
- Next grant to a waiting requester: after M+GAP_CYCLES+1 (GAP, then SETUP).
- Preemption: the owner gets exactly MAX_HOLD grant cycles; gnt drops on the following edge.
- Requesters must tolerate gnt being withdrawn while their req is still high. They re-arbitrate by holding req.
- Simultaneous release by the owner and request by the other requester in the same cycle: handled as a normal release, then GAP, then the other requester.

## Test plan
- Reset: hold `nreset`=0 with both reqs high → `sel`=0, `ng`=1, `gnt_a`=`gnt_b`=0, and they stay so until `nreset` rises.
- Single request: `req_a`=1 sampled at edge 0 → `sel`=0, `ng`=1 after 0; `gnt_a`=1, `ng`=0 after 1. Drop `req_a` before edge 5 → `gnt_a`=0, `ng`=1 after 5; IDLE after 6 (GAP_CYCLES=1).
- Tie plus round-robin: both reqs asserted at the same edge out of reset → A is granted first. A releases → one GAP cycle, SETUP with `sel`=1, then `gnt_b`=1. Repeat the tie → A wins again.
- Preemption with MAX_HOLD=4: A granted, B requests → `gnt_a` is high for exactly 4 cycles, then GAP and SETUP, then `gnt_b`. A (still requesting) regains the path after B releases. A monitor checks that `sel` never toggles while `ng`=0.
- Withdraw in SETUP: pulse `req_b` for one cycle from IDLE → `sel`=1 for one cycle, return to IDLE, `gnt_b` never asserts, `last` is unchanged (verify with a following tie: B wins it).
- Asynchronous reset mid-grant: drop `nreset` between edges while `gnt_b`=1 → `gnt_b`=0, `ng`=1, `sel`=0 immediately, without waiting for a clock edge. After release, normal arbitration resumes and A wins the first tie.
